// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-by-word forward memory copy engine
// One word is read ahead into buf_q so each COPY cycle reads word k while writing word k-1.
module mem_copy_engine #(
   parameter int CORE       = 0,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] srcAddress,
   input  logic [ADDR_WIDTH-1:0] dstAddress,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  readEnable,
   output logic [ADDR_WIDTH-1:0] readAddress,
   input  logic [DATA_WIDTH-1:0] readData,
   output logic                  writeEnable,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  busy,
   output logic                  done,
   input  logic                  report
);

   typedef enum logic [2:0] {IDLE, FILL, COPY, LAST, DONE} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] src_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [ADDR_WIDTH:0]   remain_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic                  rd_en_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic                  busy_q;
   logic                  done_q;
   logic [31:0]           cycle_q;

   logic [ADDR_WIDTH-1:0] src_inc_d;
   logic [ADDR_WIDTH-1:0] dst_inc_d;
   logic [ADDR_WIDTH-1:0] start_src_inc_d;
   logic [ADDR_WIDTH:0]   remain_dec_d;

   assign src_inc_d       = src_q + ADDR_WIDTH'(1);
   assign dst_inc_d       = dst_q + ADDR_WIDTH'(1);
   assign start_src_inc_d = srcAddress + ADDR_WIDTH'(1);
   assign remain_dec_d    = remain_q - (ADDR_WIDTH+1)'(1);

   // remain_q counts reads still to issue, including the one in the current cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         remain_q  <= '0;
         buf_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cycle_q   <= '0;
      end else begin
         cycle_q   <= cycle_q + 32'd1;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         buf_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= FILL;
                     src_q     <= start_src_inc_d;
                     dst_q     <= dstAddress;
                     remain_q  <= length;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= srcAddress;
                     busy_q    <= 1'b1;
                  end
               end
            end
            FILL, COPY: begin
               busy_q    <= 1'b1;
               wr_en_q   <= 1'b1;
               wr_addr_q <= dst_q;
               dst_q     <= dst_inc_d;
               buf_q     <= readData;
               if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                  state_q  <= LAST;
                  remain_q <= '0;
               end else begin
                  state_q   <= COPY;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= src_q;
                  src_q     <= src_inc_d;
                  remain_q  <= remain_dec_d;
               end
            end
            LAST: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign readEnable   = rd_en_q;
   assign readAddress  = rd_addr_q;
   assign writeEnable  = wr_en_q;
   assign writeAddress = wr_addr_q;
   assign writeData    = buf_q;
   assign busy         = busy_q;
   assign done         = done_q;

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (reset && report)
         $write("core %0d cycle %0d state %s src %h dst %h remain %0d busy %b done %b\n",
                CORE, cycle_q, state_q.name(), src_q, dst_q, remain_q, busy_q, done_q);
   end
`endif

endmodule
